// File: rtl/exposure_readout_ctrl.sv
// exposure_readout_ctrl: REVEAL pixel-array exposure sequencer with triggered row readout sequencer
module exposure_readout_ctrl (
  input  logic        CLK,
  input  logic        rst,
  input  logic [31:0] NUM_SUB, T_reset, Tgl_res, Texp_ctrl, T_stdby,
  input  logic [31:0] T1, T2, T3, T4, T5, T6, T7, T8, T9,
  input  logic [31:0] RO_T1, RO_T2, RO_T3, RO_T4, RO_T5, RO_T6, NUM_ROW,
  output logic        PIXGLOB_RES, PIXDRAIN, PIXVTG_GLOB, EXP, PIXGSUBC, PIXROWMASK, DES, SYNC, MASK_EN, STDBY,
  output logic        trigger_o, re_busy,
  output logic [9:0]  ROWADD,
  output logic        COL_L_EN, COL_PRECH, CP_MUX_IN, MUX_START, PIXRES, PH1, PGA_RES, SAMP_R, SAMP_S, READ_R, READ_S
);
  typedef enum logic [2:0] {S_IDLE, S_GRES, S_EXPO, S_TRIG, S_WAIT, S_STBY} exp_state_t;
  typedef enum logic {R_IDLE, R_ROW} ro_state_t;
  exp_state_t st, st_n;
  ro_state_t rs, rs_n;
  logic [31:0] cnt, sub, ro_off, row, cp_at, h, rd;
  logic [8:0] slot;
  logic [9:0] addr, addr_n;
  logic [22:0] q, q_n;
  logic seen, mask, quad, last, slot_end, ro_row, ro_end;
  assign {PIXGLOB_RES, PIXDRAIN, PIXVTG_GLOB, EXP, PIXGSUBC, PIXROWMASK, DES, SYNC, MASK_EN, STDBY,
          trigger_o, re_busy, COL_L_EN, COL_PRECH, CP_MUX_IN, MUX_START, PIXRES, PH1, PGA_RES,
          SAMP_R, SAMP_S, READ_R, READ_S} = q;
  always_comb begin
    mask = st == S_EXPO && slot != 9'd0 && slot <= 9'd324;
    quad = mask && slot[1:0] == 2'b00;
    last = slot == 9'd325;
    slot_end = last ? cnt == Texp_ctrl - 32'd1 : cnt == T1 - 32'd1;
    ro_row = rs == R_ROW;
    ro_end = ro_off == RO_T1 - 32'd1;
    h = RO_T2 >> 1;
    rd = RO_T2 + ((RO_T1 - RO_T2) >> 1);
    st_n = st;
    case (st)
      S_IDLE: st_n = S_GRES;
      S_GRES: st_n = cnt == T_reset + Tgl_res - 32'd1 ? S_EXPO : S_GRES;
      S_EXPO: st_n = slot_end && last && sub == NUM_SUB - 32'd1 ? S_TRIG : S_EXPO;
      S_TRIG: st_n = S_WAIT;
      S_WAIT: st_n = seen && !ro_row ? S_STBY : S_WAIT;
      S_STBY: st_n = cnt == T_stdby - 32'd1 ? S_GRES : S_STBY;
      default: st_n = S_IDLE;
    endcase
    rs_n = ro_row ? ((ro_end && row == NUM_ROW - 32'd1) ? R_IDLE : R_ROW) : (st == S_TRIG ? R_ROW : R_IDLE);
    addr_n = st == S_GRES ? 10'd0 : (quad && cnt == T6) ? 10'(slot[8:2]) - 10'd1 : addr;
    q_n = {
      st == S_GRES,
      st == S_GRES && cnt < T_reset,
      st == S_GRES && cnt < T_reset,
      st == S_EXPO,
      st == S_EXPO && slot == 9'd0 && cnt < T9,
      mask,
      mask && cnt >= T2 && cnt < T2 + T3,
      quad && cnt >= T4 && cnt < T4 + T5,
      quad && cnt >= T7 && cnt < T7 + T8,
      st == S_STBY,
      st == S_TRIG,
      ro_row,
      ro_row && ro_off < RO_T2,
      ro_row && ro_off < RO_T3,
      ro_row && ro_off < RO_T2 && ro_off == cp_at,
      ro_row && ro_off >= RO_T2 && ro_off < RO_T2 + RO_T4,
      ro_row && ro_off >= h && ro_off < h + RO_T5,
      ro_row && ro_off < RO_T2,
      ro_row && ro_off < RO_T3,
      ro_row && ro_off >= RO_T3 && ro_off < h,
      ro_row && ro_off >= h + RO_T5 && ro_off < RO_T2,
      ro_row && ro_off >= RO_T2 && ro_off < rd,
      ro_row && ro_off >= rd
    };
  end
  always_ff @(posedge CLK) begin
    if (rst) begin
      st <= S_IDLE;
      rs <= R_IDLE;
      cnt <= '0;
      sub <= '0;
      slot <= '0;
      ro_off <= '0;
      row <= '0;
      cp_at <= '0;
      addr <= '0;
      seen <= 1'b0;
      q <= '0;
      ROWADD <= '0;
    end else begin
      st <= st_n;
      rs <= rs_n;
      q <= q_n;
      addr <= addr_n;
      ROWADD <= ro_row ? row[9:0] : addr_n;
      seen <= st == S_WAIT && (seen || ro_row);
      cnt <= (st_n != st || (st == S_EXPO && slot_end)) ? 32'd0 : cnt + 32'd1;
      slot <= st != S_EXPO ? 9'd0 : !slot_end ? slot : last ? 9'd0 : slot + 9'd1;
      sub <= st != S_EXPO ? 32'd0 : (slot_end && last) ? sub + 32'd1 : sub;
      ro_off <= (!ro_row || ro_end) ? 32'd0 : ro_off + 32'd1;
      row <= !ro_row ? 32'd0 : !ro_end ? row : row == NUM_ROW - 32'd1 ? 32'd0 : row + 32'd1;
      cp_at <= (!ro_row || ro_end) ? RO_T5 : ro_off == cp_at ? cp_at + RO_T6 : cp_at;
    end
  end
endmodule

// File: tb/tb_exposure_readout_ctrl.sv
// tb_exposure_readout_ctrl: directed self-checking bench for exposure_readout_ctrl
module tb_exposure_readout_ctrl;
  logic CLK = 1'b0;
  logic rst;
  logic [31:0] NUM_SUB, T_reset, Tgl_res, Texp_ctrl, T_stdby;
  logic [31:0] T1, T2, T3, T4, T5, T6, T7, T8, T9;
  logic [31:0] RO_T1, RO_T2, RO_T3, RO_T4, RO_T5, RO_T6, NUM_ROW;
  logic PIXGLOB_RES, PIXDRAIN, PIXVTG_GLOB, EXP, PIXGSUBC, PIXROWMASK, DES, SYNC, MASK_EN, STDBY;
  logic trigger_o, re_busy;
  logic [9:0] ROWADD;
  logic COL_L_EN, COL_PRECH, CP_MUX_IN, MUX_START, PIXRES, PH1, PGA_RES, SAMP_R, SAMP_S, READ_R, READ_S;
  logic [22:0] outs;
  logic [22:0] pv = '0;
  int r1[23], r2[23], f1[23], nr[23];
  int ta1 = -1, tr1 = -1, tr2 = -1, ra_end = -1;
  int cyc = 0, checks = 0, errors = 0, n;
  bit mon = 1'b0;
  exposure_readout_ctrl dut (
    .CLK(CLK), .rst(rst),
    .NUM_SUB(NUM_SUB), .T_reset(T_reset), .Tgl_res(Tgl_res), .Texp_ctrl(Texp_ctrl), .T_stdby(T_stdby),
    .T1(T1), .T2(T2), .T3(T3), .T4(T4), .T5(T5), .T6(T6), .T7(T7), .T8(T8), .T9(T9),
    .RO_T1(RO_T1), .RO_T2(RO_T2), .RO_T3(RO_T3), .RO_T4(RO_T4), .RO_T5(RO_T5), .RO_T6(RO_T6), .NUM_ROW(NUM_ROW),
    .PIXGLOB_RES(PIXGLOB_RES), .PIXDRAIN(PIXDRAIN), .PIXVTG_GLOB(PIXVTG_GLOB), .EXP(EXP), .PIXGSUBC(PIXGSUBC),
    .PIXROWMASK(PIXROWMASK), .DES(DES), .SYNC(SYNC), .MASK_EN(MASK_EN), .STDBY(STDBY),
    .trigger_o(trigger_o), .re_busy(re_busy), .ROWADD(ROWADD),
    .COL_L_EN(COL_L_EN), .COL_PRECH(COL_PRECH), .CP_MUX_IN(CP_MUX_IN), .MUX_START(MUX_START), .PIXRES(PIXRES),
    .PH1(PH1), .PGA_RES(PGA_RES), .SAMP_R(SAMP_R), .SAMP_S(SAMP_S), .READ_R(READ_R), .READ_S(READ_S)
  );
  assign outs = {PGA_RES, PH1, PIXVTG_GLOB, READ_S, READ_R, SAMP_S, PIXRES, SAMP_R, MUX_START, CP_MUX_IN,
                 COL_PRECH, COL_L_EN, re_busy, trigger_o, STDBY, MASK_EN, SYNC, DES, PIXROWMASK, PIXGSUBC,
                 EXP, PIXDRAIN, PIXGLOB_RES};
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;
  always @(negedge CLK) begin
    if (mon) begin
      for (int i = 0; i < 23; i++) begin
        if (outs[i] && !pv[i]) begin
          nr[i]++;
          if (nr[i] == 1) r1[i] = cyc;
          else if (nr[i] == 2) r2[i] = cyc;
        end
        if (!outs[i] && pv[i] && f1[i] < 0) f1[i] = cyc;
      end
      if (!re_busy && ROWADD == 10'd1 && ta1 < 0) ta1 = cyc;
      if (re_busy && ROWADD == 10'd1 && tr1 < 0) tr1 = cyc;
      if (re_busy && ROWADD == 10'd2 && tr2 < 0) tr2 = cyc;
      if (!re_busy && pv[10] && ra_end < 0) ra_end = int'(ROWADD);
    end
    pv = outs;
  end
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  initial begin
    for (int i = 0; i < 23; i++) begin
      r1[i] = -1;
      r2[i] = -1;
      f1[i] = -1;
      nr[i] = 0;
    end
    rst = 1'b1;
    NUM_SUB = 3; T_reset = 20; Tgl_res = 10; Texp_ctrl = 16; T_stdby = 100;
    T1 = 16; T2 = 1; T3 = 1; T4 = 1; T5 = 1; T6 = 1; T7 = 1; T8 = 1; T9 = 1;
    RO_T1 = 1724; RO_T2 = 862; RO_T3 = 2; RO_T4 = 3; RO_T5 = 2; RO_T6 = 20; NUM_ROW = 20;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_outs", int'(outs), 0);
    chk("reset_rowadd", int'(ROWADD), 0);
    rst = 1'b0;
    mon = 1'b1;
    for (int i = 0; i < 60000 && nr[0] < 2; i++) @(posedge CLK);
    @(negedge CLK);
    mon = 1'b0;
    chk("frame1_done", int'(nr[0] >= 2), 1);
    chk("gres_width", f1[0] - r1[0], 30);
    chk("drain_width", f1[1] - r1[1], 20);
    chk("drain_rise", r1[1] - r1[0], 0);
    chk("vtg_width", f1[20] - r1[20], 20);
    chk("exp_after_gres", r1[2] - f1[0], 0);
    chk("gsubc_at_exp", r1[3] - r1[2], 0);
    chk("gsubc_width", f1[3] - r1[3], 1);
    chk("gsubc_to_des", r1[5] - r1[3], 17);
    chk("des_period", r2[5] - r1[5], 16);
    chk("des_width", f1[5] - r1[5], 1);
    chk("gsubc_to_sync", r1[6] - r1[3], 65);
    chk("sync_width", f1[6] - r1[6], 1);
    chk("gsubc_to_mask_en", r1[7] - r1[3], 65);
    chk("mask_en_width", f1[7] - r1[7], 1);
    chk("rowadd_exp_1", ta1 - r1[3], 129);
    chk("rowmask_to_gsubc", r2[3] - r1[4], 5200);
    chk("subframe_period", r2[3] - r1[3], 5216);
    chk("gsubc_count", nr[3], 3);
    chk("exp_width", f1[2] - r1[2], 15648);
    chk("trig_at_exp_end", r1[9] - f1[2], 0);
    chk("trig_width", f1[9] - r1[9], 1);
    chk("trig_count", nr[9], 1);
    chk("trig_to_busy", r1[10] - r1[9], 1);
    chk("busy_width", f1[10] - r1[10], 34480);
    chk("col_l_en_rise", r1[11] - r1[10], 0);
    chk("col_l_en_width", f1[11] - r1[11], 862);
    chk("row_period", r2[11] - r1[11], 1724);
    chk("ph1_width", f1[21] - r1[21], 862);
    chk("col_prech_width", f1[12] - r1[12], 2);
    chk("pga_res_width", f1[22] - r1[22], 2);
    chk("prech_to_cp_mux", r1[13] - r1[12], 2);
    chk("cp_mux_period", r2[13] - r1[13], 20);
    chk("cp_mux_count", nr[13], 860);
    chk("mux_start_offset", r1[14] - r1[11], 862);
    chk("mux_start_width", f1[14] - r1[14], 3);
    chk("samp_r_offset", r1[15] - r1[11], 2);
    chk("samp_r_width", f1[15] - r1[15], 429);
    chk("pixres_offset", r1[16] - r1[11], 431);
    chk("pixres_width", f1[16] - r1[16], 2);
    chk("samp_s_width", f1[17] - r1[17], 429);
    chk("read_r_offset", r1[18] - r1[11], 862);
    chk("read_r_width", f1[18] - r1[18], 431);
    chk("read_s_offset", r1[19] - r1[11], 1293);
    chk("read_s_width", f1[19] - r1[19], 431);
    chk("rowadd_ro_1", tr1 - r1[10], 1724);
    chk("rowadd_ro_2", tr2 - tr1, 1724);
    chk("rowadd_after_ro", ra_end, 80);
    chk("busy_to_stdby", r1[8] - f1[10], 1);
    chk("stdby_width", f1[8] - r1[8], 100);
    chk("gres_restart", r2[0] - f1[8], 0);
    for (int i = 0; i < 20000 && !re_busy; i++) @(negedge CLK);
    chk("frame2_busy", int'(re_busy), 1);
    repeat (100) @(negedge CLK);
    rst = 1'b1;
    @(negedge CLK);
    chk("midrst_outs", int'(outs), 0);
    chk("midrst_rowadd", int'(ROWADD), 0);
    repeat (2) @(negedge CLK);
    rst = 1'b0;
    @(negedge CLK);
    chk("restart_idle", int'(outs), 0);
    @(negedge CLK);
    chk("restart_gres", int'(PIXGLOB_RES), 1);
    chk("restart_drain", int'(PIXDRAIN), 1);
    chk("restart_busy", int'(re_busy), 0);
    n = 0;
    for (int i = 0; i < 100 && PIXGLOB_RES; i++) begin
      n++;
      @(negedge CLK);
    end
    chk("restart_gres_width", n, 30);
    chk("restart_exp", int'(EXP), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/exposure_readout_ctrl.md
# exposure_readout_ctrl

Pixel-array sequencer for the REVEAL sensor. It contains an exposure sequencer (global reset, then NUM_SUB coded-mask subframes) and a row readout sequencer started by the exposure sequencer. Its outputs drive the sensor pins directly. All durations are programmable in CLK cycles.

## Interface
- Parameters: none. All timings are run-time inputs, unsigned, in CLK cycles; every T input must be ≥1.
- CLK  in  1  system clock (100 MHz nominal)
- rst  in  1  synchronous, active-high reset
- NUM_SUB  in  32  subframes per frame (≥1)
- T_reset, Tgl_res, Texp_ctrl, T_stdby  in  32 each  exposure phase durations
- T1..T9  in  32 each  exposure row-slot timings; T1 > max(T2+T3, T4+T5, T7+T8, T6, T9)
- RO_T1..RO_T6  in  32 each  readout timings; RO_T1 > RO_T2+RO_T4, RO_T5 < RO_T2
- NUM_ROW  in  32  rows read per frame (≥1)
- PIXGLOB_RES, PIXDRAIN, PIXVTG_GLOB, EXP, PIXGSUBC, PIXROWMASK, DES, SYNC, MASK_EN, STDBY  out  1 each  exposure pixel controls
- trigger_o  out  1  one-cycle pulse that starts readout
- re_busy  out  1  readout in progress
- ROWADD  out  10  row address: the readout address while re_busy=1, otherwise the exposure address
- COL_L_EN, COL_PRECH, CP_MUX_IN, MUX_START, PIXRES, PH1, PGA_RES, SAMP_R, SAMP_S, READ_R, READ_S  out  1 each  readout controls

## Operation
Exposure state machine: IDLE → GRES → EXPO → TRIG → WAIT_RO → STDBY → GRES, and so on.
- IDLE: lasts one cycle after rst is released.
- GRES lasts T_reset+Tgl_res cycles.
  - PIXGLOB_RES=1 throughout.
  - PIXDRAIN=1 and PIXVTG_GLOB=1 for the first T_reset cycles only.
- EXPO: EXP=1. NUM_SUB subframes run back to back. One subframe is:
  - one GSUB slot of T1 cycles, with PIXGSUBC=1 for its first T9 cycles;
  - then 324 mask-load slots k=0..323, each T1 cycles, with PIXROWMASK=1 for all of them;
  - then Texp_ctrl idle cycles.
- Within mask-load slot k (o = cycle offset within the slot, starting at 0):
  - DES=1 for o in [T2, T2+T3).
  - If k mod 4 = 3: SYNC=1 for o in [T4, T4+T5), and MASK_EN=1 for o in [T7, T7+T8).
  - If k mod 4 = 3: at o=T6, ROWADD_EXP loads g=(k−3)/4, giving values 0..80.
- TRIG: trigger_o=1 for exactly one cycle; EXP=0.
- WAIT_RO: wait until re_busy has been seen high and then low.
- STDBY: STDBY=1 for T_stdby cycles, then return to GRES. ROWADD_EXP resets to 0 on entry to GRES.

Readout state machine: IDLE → ROW → IDLE.
- On trigger_o, re_busy goes to 1 on the next cycle and NUM_ROW row slots of RO_T1 cycles each run.
- ROWADD_RO = row index r (0..NUM_ROW−1). It updates at offset 0 of each row slot.
- Within a row slot, at offset o:
  - COL_L_EN=1 and PH1=1 for [0, RO_T2).
  - COL_PRECH=1 and PGA_RES=1 for [0, RO_T3).
  - CP_MUX_IN=1 for one cycle at o = RO_T5 + n·RO_T6, for every n ≥ 0 with o < RO_T2.
  - SAMP_R=1 for [RO_T3, RO_T2/2).
  - PIXRES=1 for [RO_T2/2, RO_T2/2+RO_T5).
  - SAMP_S=1 for [RO_T2/2+RO_T5, RO_T2).
  - MUX_START=1 for [RO_T2, RO_T2+RO_T4).
  - READ_R=1 for [RO_T2, RO_T2+(RO_T1−RO_T2)/2); READ_S=1 for the remainder of the slot.
- After the last row: re_busy=0, ROWADD_RO=0, and the readout machine returns to IDLE.
- A trigger arriving while re_busy=1 is ignored.

## Timing
- Reset: every output is 0 and ROWADD=0. Both machines return to IDLE on the cycle after rst is sampled high, including when rst is asserted mid-frame.
- All outputs are registered. Every edge lands exactly at its programmed offset; there are no extra pipeline cycles.
- Interval definitions:
  - PIXGLOB_RES high time = T_reset+Tgl_res.
  - PIXGSUBC rise → next PIXGSUBC rise = 325·T1+Texp_ctrl (subframe period).
  - PIXROWMASK rise → next PIXGSUBC rise = 324·T1+Texp_ctrl.
  - PIXGSUBC rise → first DES rise = T1+T2; first SYNC rise = 4·T1+T4; first MASK_EN rise = 4·T1+T7.
  - First visible ROWADD_EXP change (0→1) = PIXGSUBC rise + 8·T1+T6.
- trigger_o → re_busy=1: one cycle. re_busy high time = NUM_ROW·RO_T1.
- Divisions truncate (integer). Arithmetic is 32-bit unsigned.

## Test plan
- Global reset, T_reset=20, Tgl_res=10: PIXGLOB_RES high for 30 cycles; PIXDRAIN falls after 20.
- Exposure row slot, T1=16 and T2..T9=1: consecutive DES rises 16 cycles apart, DES width 1.
  - PIXGSUBC width 1; PIXGSUBC→DES = 17 cycles; PIXGSUBC→SYNC = 65; PIXGSUBC→MASK_EN = 65.
  - SYNC and MASK_EN widths 1.
  - ROWADD 0→1 at PIXGSUBC+129.
- Subframe, NUM_SUB=3, Texp_ctrl=16: PIXROWMASK rise → next PIXGSUBC = 5200 cycles; EXP covers exactly 3 subframes.
- Handshake: trigger_o is a single pulse; re_busy rises 1 cycle later; STDBY=1 for 100 cycles only after re_busy falls; then GRES restarts.
- Readout, RO_T1=1724, RO_T2=862, RO_T3=2, RO_T4=3, RO_T5=2, RO_T6=20, NUM_ROW=20:
  - ROWADD_RO changes every 1724 cycles; COL_L_EN width 862; COL_PRECH width 2; MUX_START width 3.
  - COL_PRECH→CP_MUX_IN = 2; CP_MUX_IN period 20.
  - re_busy width 34480.
- rst asserted mid-readout: all outputs are 0 on the next cycle and the sequence restarts from GRES after release.
